// File: rtl/synapse_receiver.sv
// Postsynaptic receiver: rising-edge spike detection per input, weighted
// accumulation into a leaky signed Q16.16 current register with saturation.

module synapse_lane #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         synin,
    input  logic         we,
    input  logic [N-1:0] wr_data,
    output logic         hit,
    output logic [N-1:0] weight
);
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev   <= 1'b0;
            weight <= '0;
        end else begin
            prev <= synin;
            if (we) weight <= wr_data;
        end
    end

    // Combinational edge so the weight used is the one held before any same-cycle write
    assign hit = synin & ~prev;
endmodule

module synapse_receiver #(
    parameter int N           = 32,
    parameter int M           = 4,
    parameter int DECAY_SHIFT = 4,
    parameter int CNT_W       = 16,
    localparam int AW         = (M > 1) ? $clog2(M) : 1,
    localparam int SW         = N + $clog2(M) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [M-1:0]        synin,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [N-1:0]        wr_data,
    output logic signed [N-1:0] I_out,
    output logic                sat,
    output logic [CNT_W-1:0]    spike_cnt
);
    logic [M-1:0]                hit;
    logic [M-1:0][N-1:0]         weight;
    logic signed [SW-1:0]        i_ext, dec, sum, nxt;
    logic [CNT_W-1:0]            pc;
    logic                        ovf;
    logic [N-1:0]                clipped;

    for (genvar k = 0; k < M; k++) begin : g_lane
        // Addresses >= M match no lane, so those writes fall away
        synapse_lane #(.N(N)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .synin   (synin[k]),
            .we      (wr_en && (wr_addr == AW'(k))),
            .wr_data (wr_data),
            .hit     (hit[k]),
            .weight  (weight[k])
        );
    end

    always_comb begin
        sum = '0;
        pc  = '0;
        for (int k = 0; k < M; k++) begin
            if (hit[k]) sum = sum + {{(SW-N){weight[k][N-1]}}, weight[k]};
            pc = pc + CNT_W'(hit[k]);
        end
    end

    // Arithmetic shift floors toward -inf: small positives stick, negatives reach 0
    assign i_ext = {{(SW-N){I_out[N-1]}}, I_out};
    assign dec   = i_ext - (i_ext >>> DECAY_SHIFT);
    assign nxt   = dec + sum;

    // Result fits in N bits only if all bits from N-1 upward agree
    assign ovf     = (|nxt[SW-1:N-1]) & ~(&nxt[SW-1:N-1]);
    assign clipped = !ovf       ? nxt[N-1:0] :
                     nxt[SW-1]  ? {1'b1, {(N-1){1'b0}}} :
                                  {1'b0, {(N-1){1'b1}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            I_out     <= '0;
            sat       <= 1'b0;
            spike_cnt <= '0;
        end else begin
            I_out     <= clipped;
            sat       <= ovf;
            spike_cnt <= spike_cnt + pc;
        end
    end
endmodule
